// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter: shifts a WIDTH-bit word out MSB-first with
// sof/eof framing and the multiple-of-4 verdict (exp_z) a downstream detector must report.
module serial_word_tx #(
  parameter int WIDTH = 8,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             sof,
  output logic             eof,
  output logic             exp_z,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = 4;

  localparam logic [CW-1:0] BIT_LAST  = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_START = GW'((GAP > 0) ? GAP - 1 : 0);

  // Handshake: a word transfers on any rising edge where din_valid && din_ready;
  // the producer holds din stable until then and din is sampled only at that edge.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    bcnt_q, bcnt_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic [1:0]       lo_q, lo_d;
  logic             x_q, x_d;
  logic             xv_q, xv_d;
  logic             sof_q, sof_d;
  logic             eof_q, eof_d;
  logic             ez_q, ez_d;
  logic             busy_q, busy_d;
  logic             last_bit;
  logic             take;

  assign last_bit  = (state_q == S_SHIFT) && (bcnt_q == '0);
  assign din_ready = rst && ((state_q == S_IDLE) || (last_bit && (GAP == 0)));
  assign take      = din_valid && din_ready;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bcnt_d  = bcnt_q;
    gcnt_d  = gcnt_q;
    lo_d    = lo_q;
    x_d     = 1'b0;
    xv_d    = 1'b0;
    sof_d   = 1'b0;
    eof_d   = 1'b0;
    ez_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (take) begin
          state_d = S_SHIFT;
          sr_d    = din;
          bcnt_d  = BIT_LAST;
          lo_d    = din[1:0];
        end
      end

      S_SHIFT: begin
        x_d    = sr_q[WIDTH-1];
        xv_d   = 1'b1;
        sof_d  = (bcnt_q == BIT_LAST);
        eof_d  = (bcnt_q == '0);
        ez_d   = (bcnt_q == '0) && (lo_q == 2'b00);
        sr_d   = sr_q << 1;
        bcnt_d = bcnt_q - CW'(1);
        if (bcnt_q == '0) begin
          if (GAP > 0) begin
            state_d = S_GAP;
            gcnt_d  = GAP_START;
          end else if (take) begin
            // Back-to-back reload: next MSB follows the LSB with no bubble.
            sr_d   = din;
            bcnt_d = BIT_LAST;
            lo_d   = din[1:0];
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_GAP: begin
        // Leave one cycle early so IDLE's accept edge is the last idle bit slot,
        // giving exactly GAP zero cycles between words when the producer is waiting.
        if (gcnt_q <= GW'(1)) begin
          state_d = S_IDLE;
          gcnt_d  = '0;
        end else begin
          gcnt_d = gcnt_q - GW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      bcnt_q  <= '0;
      gcnt_q  <= '0;
      lo_q    <= '0;
      x_q     <= 1'b0;
      xv_q    <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      ez_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bcnt_q  <= bcnt_d;
      gcnt_q  <= gcnt_d;
      lo_q    <= lo_d;
      x_q     <= x_d;
      xv_q    <= xv_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      ez_q    <= ez_d;
      busy_q  <= busy_d;
    end
  end

  assign x       = x_q;
  assign x_valid = xv_q;
  assign sof     = sof_q;
  assign eof     = eof_q;
  assign exp_z   = ez_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: two instances (GAP=0 and GAP=3) checked every cycle
// against a queue-of-output-slots reference model, plus a multiple-of-4 detector.
module tb_serial_word_tx;

  localparam int W     = 8;
  localparam int GAP_B = 3;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [W-1:0] din_a, din_b;
  logic         vld_a, vld_b;
  logic         rdy_a, x_a, xv_a, sof_a, eof_a, ez_a, busy_a;
  logic         rdy_b, x_b, xv_b, sof_b, eof_b, ez_b, busy_b;

  serial_word_tx #(.WIDTH(W), .GAP(0)) dut_a (
    .clk(clk), .rst(rst), .din(din_a), .din_valid(vld_a), .din_ready(rdy_a),
    .x(x_a), .x_valid(xv_a), .sof(sof_a), .eof(eof_a), .exp_z(ez_a), .busy(busy_a)
  );

  serial_word_tx #(.WIDTH(W), .GAP(GAP_B)) dut_b (
    .clk(clk), .rst(rst), .din(din_b), .din_valid(vld_b), .din_ready(rdy_b),
    .x(x_b), .x_valid(xv_b), .sof(sof_b), .eof(eof_b), .exp_z(ez_b), .busy(busy_b)
  );

  // scoreboard
  int vectors     = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: each queue entry is one future output cycle {x_valid,x,sof,eof,exp_z}.
  // A word becomes WIDTH bit slots followed by GAP zero slots; a new word may be
  // accepted once at most one slot remains pending.
  logic [4:0] exp_q_a[$];
  logic [4:0] exp_q_b[$];
  logic [4:0] cur_a = '0, cur_b = '0;
  logic       took_a = 1'b0, took_b = 1'b0;

  function automatic logic [4:0] slot(input logic [W-1:0] w, input int i);
    logic last;
    last = (i == 0);
    return {1'b1, w[i], (i == W - 1), last, last && (w % 4 == 0)};
  endfunction

  always @(posedge clk) begin
    took_a = rst && vld_a && (exp_q_a.size() <= 1);
    took_b = rst && vld_b && (exp_q_b.size() <= 1);
    if (!rst) begin
      exp_q_a.delete();
      exp_q_b.delete();
      cur_a = '0;
      cur_b = '0;
    end else begin
      cur_a = (exp_q_a.size() > 0) ? exp_q_a.pop_front() : 5'd0;
      cur_b = (exp_q_b.size() > 0) ? exp_q_b.pop_front() : 5'd0;
      if (took_a)
        for (int i = W - 1; i >= 0; i--) exp_q_a.push_back(slot(din_a, i));
      if (took_b) begin
        for (int i = W - 1; i >= 0; i--) exp_q_b.push_back(slot(din_b, i));
        for (int g = 0; g < GAP_B; g++) exp_q_b.push_back(5'd0);
      end
    end
  end

  // Multiple-of-4 detector fed by instance A's stream.
  logic prev_bit = 1'b0;
  logic det_z    = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      prev_bit <= 1'b0;
      det_z    <= 1'b0;
    end else if (xv_a) begin
      prev_bit <= x_a;
      if (eof_a) det_z <= !prev_bit && !x_a;
    end
  end

  // driver
  logic [W-1:0] send_q_a[$];
  logic [W-1:0] send_q_b[$];
  logic         hold_a = 1'b1, hold_b = 1'b1;

  task automatic drive();
    if (!(vld_a && !took_a)) begin
      if (send_q_a.size() > 0 && (hold_a || $urandom_range(0, 2) != 0)) begin
        vld_a = 1'b1;
        din_a = send_q_a.pop_front();
      end else begin
        vld_a = 1'b0;
        din_a = W'($urandom);
      end
    end
    if (!(vld_b && !took_b)) begin
      if (send_q_b.size() > 0 && (hold_b || $urandom_range(0, 2) != 0)) begin
        vld_b = 1'b1;
        din_b = send_q_b.pop_front();
      end else begin
        vld_b = 1'b0;
        din_b = W'($urandom);
      end
    end
  endtask

  task automatic compare_all();
    check_eq("rdy_a", rdy_a, rst && (exp_q_a.size() <= 1));
    check_eq("out_a", {xv_a, x_a, sof_a, eof_a, ez_a}, cur_a);
    check_eq("busy_a", busy_a, exp_q_a.size() > 0);
    check_eq("rdy_b", rdy_b, rst && (exp_q_b.size() <= 1));
    check_eq("out_b", {xv_b, x_b, sof_b, eof_b, ez_b}, cur_b);
    check_eq("busy_b", busy_b, exp_q_b.size() > 1);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
    compare_all();
    drive();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((send_q_a.size() + send_q_b.size() + exp_q_a.size() + exp_q_b.size() > 0
            || vld_a || vld_b) && n < 3000) begin
      tick();
      n++;
    end
    check_eq(tag, send_q_a.size() + send_q_b.size() + exp_q_a.size() + exp_q_b.size(), 0);
  endtask

  logic [W-1:0] dir_words[6] = '{8'hCC, 8'h06, 8'h03, 8'h00, 8'hA5, 8'h3C};

  initial begin
    int   nbits;
    logic ez_seen;

    rst   = 1'b0;
    vld_a = 1'b1;
    vld_b = 1'b1;
    din_a = W'($urandom);
    din_b = W'($urandom);
    tick();
    tick();
    check_eq("reset_rdy_a", rdy_a, 0);
    check_eq("reset_outs_a", {x_a, xv_a, sof_a, eof_a, ez_a, busy_a}, 0);
    check_eq("reset_outs_b", {x_b, xv_b, sof_b, eof_b, ez_b, busy_b}, 0);
    rst = 1'b1;
    #1;
    check_eq("post_reset_rdy_a", rdy_a, 1);
    check_eq("post_reset_busy_a", busy_a, 0);
    drain("drain_init");

    // directed words, valid held high: back-to-back on A, GAP-spaced on B
    foreach (dir_words[i]) begin
      send_q_a.push_back(dir_words[i]);
      send_q_b.push_back(dir_words[i]);
    end
    drive();
    drain("drain_directed");

    // randomized words with random valid bubbles
    hold_a = 1'b0;
    hold_b = 1'b0;
    for (int i = 0; i < 60; i++) begin
      send_q_a.push_back(W'($urandom));
      send_q_b.push_back(($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15) * 4) : W'($urandom));
    end
    drive();
    drain("drain_random");

    // mid-word reset on 8'hFF during its 4th bit
    hold_a = 1'b1;
    send_q_a.push_back(8'hFF);
    drive();
    nbits = 0;
    for (int i = 0; i < 40 && nbits < 4; i++) begin
      tick();
      if (xv_a) nbits++;
    end
    check_eq("ff_bits_seen", nbits, 4);
    rst = 1'b0;
    tick();
    check_eq("rst_mid_xv", xv_a, 0);
    check_eq("rst_mid_eof", eof_a, 0);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) tick();

    // 8'h0C through the detector
    send_q_a.push_back(8'h0C);
    drive();
    for (int i = 0; i < 40 && !(xv_a && eof_a); i++) tick();
    check_eq("eof_0c", eof_a, 1);
    ez_seen = ez_a;
    tick();
    check_eq("det_z_0c", det_z, 1);
    check_eq("det_z_vs_exp", det_z, ez_seen);
    drain("drain_final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
